// File: rtl/fifo_sync_param_pkg.sv
// Shared FIFO definitions: default geometry, count width and the parameter
// legality check that each FIFO variant applies at elaboration.
package fifo_sync_param_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

  // One extra bit so a count of exactly DEPTH is representable.
  function automatic int unsigned countWidth(input int unsigned addrWidth);
    return addrWidth + 1;
  endfunction

  function automatic bit paramsLegal(input int unsigned addrWidth,
                                     input int unsigned almostEmptyLevel,
                                     input int unsigned almostFullLevel);
    return (addrWidth >= 1) && (almostEmptyLevel > 0) &&
           (almostEmptyLevel < almostFullLevel) &&
           (almostFullLevel <= (2 ** addrWidth));
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port; kept separate so a vendor RAM can replace it.
module fifo_ram_dp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_inputClock,
  input  logic                  i_writeEnable,
  input  logic [ADDR_WIDTH-1:0] i_writeAddr,
  input  logic [DATA_WIDTH-1:0] i_writeData,
  input  logic [ADDR_WIDTH-1:0] i_readAddr,
  output logic [DATA_WIDTH-1:0] o_readData
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge i_inputClock) begin
    if (i_writeEnable) begin
      mem[i_writeAddr] <= i_writeData;
    end
  end

  assign o_readData = mem[i_readAddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock first-word-fall-through FIFO with fill count,
// almost-full/almost-empty flags, sticky error flags and synchronous flush.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
  parameter int unsigned ALMOST_FULL_LEVEL  = 2**ADDR_WIDTH - 4,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                  i_clock,
  input  logic                  i_resetN,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_writeData,
  input  logic                  i_writeEnable,
  output logic                  o_fullFlag,
  output logic                  o_almostFull,
  input  logic                  i_readEnable,
  output logic [DATA_WIDTH-1:0] o_readData,
  output logic                  o_emptyFlag,
  output logic                  o_almostEmpty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned CW = countWidth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = CW'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = CW'(ALMOST_EMPTY_LEVEL);

  if (!paramsLegal(ADDR_WIDTH, ALMOST_EMPTY_LEVEL, ALMOST_FULL_LEVEL)) begin : g_paramCheck
    $error("fifo_sync_param: need ADDR_WIDTH>=1 and 0<ALMOST_EMPTY_LEVEL<ALMOST_FULL_LEVEL<=DEPTH");
  end

  logic [ADDR_WIDTH:0]   writePtr;
  logic [ADDR_WIDTH:0]   readPtr;
  logic                  isEmpty;
  logic                  isFull;
  logic                  pushOk;
  logic                  popOk;
  logic                  ramWrite;
  logic [DATA_WIDTH-1:0] ramReadData;

  // Every flag and the count derive from registered pointers only, so
  // neither enable has a combinational path to an output.
  assign isEmpty  = (writePtr == readPtr);
  assign isFull   = (writePtr[ADDR_WIDTH] != readPtr[ADDR_WIDTH]) &&
                    (writePtr[ADDR_WIDTH-1:0] == readPtr[ADDR_WIDTH-1:0]);
  assign pushOk   = i_writeEnable && !isFull;
  assign popOk    = i_readEnable && !isEmpty;
  assign ramWrite = pushOk && i_resetN && !i_clear;

  always_ff @(posedge i_clock) begin
    if (!i_resetN || i_clear) begin
      writePtr    <= '0;
      readPtr     <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (pushOk) begin
        writePtr <= writePtr + 1'b1;
      end
      if (popOk) begin
        readPtr <= readPtr + 1'b1;
      end
      if (i_writeEnable && isFull) begin
        o_overflow <= 1'b1;
      end
      if (i_readEnable && isEmpty) begin
        o_underflow <= 1'b1;
      end
    end
  end

  fifo_ram_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_inputClock (i_clock),
    .i_writeEnable(ramWrite),
    .i_writeAddr  (writePtr[ADDR_WIDTH-1:0]),
    .i_writeData  (i_writeData),
    .i_readAddr   (readPtr[ADDR_WIDTH-1:0]),
    .o_readData   (ramReadData)
  );

  assign o_count       = writePtr - readPtr;
  assign o_emptyFlag   = isEmpty;
  assign o_fullFlag    = isFull;
  assign o_almostFull  = (o_count >= AF_LEVEL);
  assign o_almostEmpty = (o_count <= AE_LEVEL);
  assign o_readData    = isEmpty ? '0 : ramReadData;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at default geometry (32 x 256).
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        resetN;
  logic        clear;
  logic [31:0] writeData;
  logic        writeEnable;
  logic        readEnable;
  logic        fullFlag, almostFull, emptyFlag, almostEmpty;
  logic        overflow, underflow;
  logic [31:0] readData;
  logic [8:0]  count;

  int unsigned passCount  = 0;
  int unsigned totalCount = 0;

  fifo_sync_param #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8)
  ) dut (
    .i_clock      (clk),
    .i_resetN     (resetN),
    .i_clear      (clear),
    .i_writeData  (writeData),
    .i_writeEnable(writeEnable),
    .o_fullFlag   (fullFlag),
    .o_almostFull (almostFull),
    .i_readEnable (readEnable),
    .o_readData   (readData),
    .o_emptyFlag  (emptyFlag),
    .o_almostEmpty(almostEmpty),
    .o_count      (count),
    .o_overflow   (overflow),
    .o_underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, we, re;
    logic [31:0] wd;
    int unsigned cnt;
    logic        emp, ful, ae, af, ovf, unf;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    clear = 1'b0; writeEnable = 1'b0; readEnable = 1'b0; writeData = '0;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".empty"}, 32'(emptyFlag), 32'd1);
    check({tag, ".almostEmpty"}, 32'(almostEmpty), 32'd1);
    check({tag, ".full"}, 32'(fullFlag), 32'd0);
    check({tag, ".almostFull"}, 32'(almostFull), 32'd0);
    check({tag, ".overflow"}, 32'(overflow), 32'd0);
    check({tag, ".underflow"}, 32'(underflow), 32'd0);
    check({tag, ".readData"}, readData, 32'd0);
  endtask

  task automatic doReset();
    idleInputs();
    resetN = 1'b0;
    step(); step();
    resetN = 1'b1;
  endtask

  task automatic pushWord(input logic [31:0] d);
    writeEnable = 1'b1; writeData = d;
    step();
    writeEnable = 1'b0;
  endtask

  logic [31:0] model[$];
  logic [31:0] rnd;

  initial begin
    // FWFT, underflow-with-push, clear-with-push and almost-empty boundary.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,        0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h55,       1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h66,       2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h66};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h77,       0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h11,       1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h22,       2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h33,       3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h44,       4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h55,       5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h66,       5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h0,        4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33};

    resetN = 1'b1;
    doReset();
    checkResetState("reset");

    for (int i = 0; i < 13; i++) begin
      clear = vecs[i].clr; writeEnable = vecs[i].we; readEnable = vecs[i].re;
      writeData = vecs[i].wd;
      step();
      check($sformatf("vec%0d.count", i), 32'(count), vecs[i].cnt);
      check($sformatf("vec%0d.empty", i), 32'(emptyFlag), 32'(vecs[i].emp));
      check($sformatf("vec%0d.full", i), 32'(fullFlag), 32'(vecs[i].ful));
      check($sformatf("vec%0d.almostEmpty", i), 32'(almostEmpty), 32'(vecs[i].ae));
      check($sformatf("vec%0d.almostFull", i), 32'(almostFull), 32'(vecs[i].af));
      check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].unf));
      check($sformatf("vec%0d.readData", i), readData, vecs[i].rd);
    end
    idleInputs();

    // Fill to DEPTH, overflow, push+pop at full, then drain in order.
    doReset();
    for (int i = 1; i <= 256; i++) begin
      pushWord(32'(i));
      check($sformatf("fill%0d.count", i), 32'(count), 32'(i));
      check($sformatf("fill%0d.full", i), 32'(fullFlag), 32'(i == 256));
      check($sformatf("fill%0d.almostFull", i), 32'(almostFull), 32'(i >= 252));
      check($sformatf("fill%0d.overflow", i), 32'(overflow), 32'd0);
    end
    pushWord(32'hBAD);
    check("over.count", 32'(count), 32'd256);
    check("over.overflow", 32'(overflow), 32'd1);
    check("over.readData", readData, 32'd1);
    writeEnable = 1'b1; readEnable = 1'b1; writeData = 32'h999;
    step();
    idleInputs();
    check("fullBoth.count", 32'(count), 32'd255);
    check("fullBoth.overflow", 32'(overflow), 32'd1);
    check("fullBoth.underflow", 32'(underflow), 32'd0);
    for (int i = 2; i <= 256; i++) begin
      check($sformatf("drain%0d.data", i), readData, 32'(i));
      readEnable = 1'b1;
      step();
    end
    readEnable = 1'b0;
    check("drained.empty", 32'(emptyFlag), 32'd1);
    check("drained.count", 32'(count), 32'd0);
    check("drained.readData", readData, 32'd0);

    // Steady push+pop at count 10 against a queue model; pointers wrap.
    doReset();
    model.delete();
    for (int i = 0; i < 10; i++) begin
      rnd = $urandom;
      model.push_back(rnd);
      pushWord(rnd);
    end
    for (int i = 0; i < 1000; i++) begin
      check($sformatf("stream%0d.data", i), readData, model[0]);
      rnd = $urandom;
      writeEnable = 1'b1; readEnable = 1'b1; writeData = rnd;
      step();
      void'(model.pop_front());
      model.push_back(rnd);
      if (count != 9'd10 || overflow || underflow)
        check($sformatf("stream%0d.count", i), 32'(count), 32'd10);
    end
    check("stream.count", 32'(count), 32'd10);
    idleInputs();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("streamDrain%0d.data", i), readData, model[0]);
      void'(model.pop_front());
      readEnable = 1'b1;
      step();
    end
    readEnable = 1'b0;
    check("streamDrain.empty", 32'(emptyFlag), 32'd1);
    check("streamDrain.errors", {30'd0, overflow, underflow}, 32'd0);

    // Clear at count 100 with push asserted, after forcing underflow.
    doReset();
    readEnable = 1'b1;
    step();
    readEnable = 1'b0;
    check("preClear.underflow", 32'(underflow), 32'd1);
    for (int i = 0; i < 100; i++) pushWord(32'(i + 1000));
    check("preClear.count", 32'(count), 32'd100);
    clear = 1'b1; writeEnable = 1'b1; writeData = 32'hCAFE;
    step();
    idleInputs();
    checkResetState("clear");

    // Reset mid-stream at count 50 with push asserted.
    for (int i = 0; i < 50; i++) pushWord(32'(i + 2000));
    check("preReset.count", 32'(count), 32'd50);
    resetN = 1'b0; writeEnable = 1'b1; writeData = 32'hF00D;
    step();
    idleInputs();
    resetN = 1'b1;
    checkResetState("midReset");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
